// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 peripheral front end.
// Byte width, bit-counter width, FSM state encoding and the default fill byte.
package spi_pkg;

  localparam int SPI_BYTE_BITS = 8;
  localparam int SPI_CNT_BITS  = $clog2(SPI_BYTE_BITS);

  localparam logic [SPI_CNT_BITS-1:0]  SPI_LAST_BIT      = 3'd7;
  localparam logic [SPI_BYTE_BITS-1:0] IDLE_FILL_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDRESS = 2'd1,
    LOAD    = 2'd2,
    DATA    = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_input_synchroniser.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with edge pulses
// derived from the synchronised value (previous vs current sample).
module spi_input_synchroniser #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchroniser chain and one-sample history; clears to low so a pin held
  // low through reset never produces a spurious falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = q & ~prev_r;
  assign fall = ~q & prev_r;

endmodule

// File: rtl/spi_peripheral_frontend.sv
// SPI mode-0 target: first byte of a chip-select window is the sub-peripheral
// address, later bytes are data in both directions; CIPO is shifted MSB first.
module spi_peripheral_frontend
  import spi_pkg::*;
#(
  parameter int                       SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_BITS-1:0] IDLE_FILL   = IDLE_FILL_DEFAULT
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     spi_sclk_in,
  input  logic                     spi_cs_n_in,
  input  logic                     spi_copi_in,
  output logic                     spi_cipo_out,
  output logic [SPI_BYTE_BITS-1:0] address_out,
  output logic                     address_out_valid,
  output logic [SPI_BYTE_BITS-1:0] data_out,
  output logic                     data_out_valid,
  input  logic [SPI_BYTE_BITS-1:0] peripheral_data_in,
  input  logic                     peripheral_data_in_valid,
  output logic                     peripheral_data_read_out
);

  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic cs_s, cs_rise_s, cs_fall_s;
  logic copi_s, copi_rise_s, copi_fall_s;
  logic unused_ok_s;

  spi_state_e                state_r, state_nxt_s;
  logic [SPI_CNT_BITS-1:0]   bit_cnt_r, bit_cnt_nxt_s;
  logic [SPI_BYTE_BITS-1:0]  rx_r, rx_nxt_s, rx_shift_s;
  logic [SPI_BYTE_BITS-1:0]  tx_r, tx_nxt_s, tx_load_s;
  logic [SPI_BYTE_BITS-1:0]  address_r, address_nxt_s;
  logic [SPI_BYTE_BITS-1:0]  data_r, data_nxt_s;
  logic                      address_valid_r, address_valid_nxt_s;
  logic                      data_valid_r, data_valid_nxt_s;
  logic                      read_r, read_nxt_s;
  logic                      cipo_r, cipo_nxt_s;
  logic                      last_bit_s;

  spi_input_synchroniser #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clock_in), .reset(reset_in), .d(spi_sclk_in),
    .q(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_input_synchroniser #(.STAGES(SYNC_STAGES)) u_sync_cs_n (
    .clk(clock_in), .reset(reset_in), .d(spi_cs_n_in),
    .q(cs_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_input_synchroniser #(.STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clock_in), .reset(reset_in), .d(spi_copi_in),
    .q(copi_s), .rise(copi_rise_s), .fall(copi_fall_s)
  );

  assign unused_ok_s = ^{sclk_s, cs_rise_s, copi_rise_s, copi_fall_s};

  assign rx_shift_s = {rx_r[SPI_BYTE_BITS-2:0], copi_s};
  assign last_bit_s = (bit_cnt_r == SPI_LAST_BIT);
  assign tx_load_s  = peripheral_data_in_valid ? peripheral_data_in : IDLE_FILL;

  // Next-state and next-output decode; a byte finishing on the same sample
  // that cs_n rises is still completed before returning to IDLE.
  always_comb begin
    state_nxt_s         = state_r;
    bit_cnt_nxt_s       = bit_cnt_r;
    rx_nxt_s            = rx_r;
    tx_nxt_s            = tx_r;
    address_nxt_s       = address_r;
    data_nxt_s          = data_r;
    address_valid_nxt_s = address_valid_r;
    data_valid_nxt_s    = 1'b0;
    read_nxt_s          = 1'b0;
    cipo_nxt_s          = cipo_r;

    case (state_r)
      IDLE: begin
        cipo_nxt_s          = 1'b0;
        address_valid_nxt_s = 1'b0;
        if (cs_fall_s) begin
          state_nxt_s   = ADDRESS;
          bit_cnt_nxt_s = {SPI_CNT_BITS{1'b0}};
          rx_nxt_s      = {SPI_BYTE_BITS{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDRESS: begin
        cipo_nxt_s = 1'b0;
        if (sclk_rise_s && last_bit_s) begin
          rx_nxt_s            = rx_shift_s;
          bit_cnt_nxt_s       = {SPI_CNT_BITS{1'b0}};
          address_nxt_s       = rx_shift_s;
          address_valid_nxt_s = ~cs_s;
          state_nxt_s         = cs_s ? IDLE : LOAD;
        end else if (cs_s) begin
          address_valid_nxt_s = 1'b0;
          state_nxt_s         = IDLE;
        end else if (sclk_rise_s) begin
          rx_nxt_s      = rx_shift_s;
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
        end else begin
          state_nxt_s = ADDRESS;
        end
      end
      LOAD: begin
        if (cs_s) begin
          address_valid_nxt_s = 1'b0;
          cipo_nxt_s          = 1'b0;
          state_nxt_s         = IDLE;
        end else begin
          tx_nxt_s      = tx_load_s;
          read_nxt_s    = peripheral_data_in_valid;
          cipo_nxt_s    = tx_load_s[SPI_BYTE_BITS-1];
          bit_cnt_nxt_s = {SPI_CNT_BITS{1'b0}};
          state_nxt_s   = DATA;
        end
      end
      DATA: begin
        if (sclk_rise_s && last_bit_s) begin
          rx_nxt_s         = rx_shift_s;
          bit_cnt_nxt_s    = {SPI_CNT_BITS{1'b0}};
          data_nxt_s       = rx_shift_s;
          data_valid_nxt_s = 1'b1;
          if (cs_s) begin
            address_valid_nxt_s = 1'b0;
            cipo_nxt_s          = 1'b0;
            state_nxt_s         = IDLE;
          end else begin
            state_nxt_s = LOAD;
          end
        end else if (cs_s) begin
          address_valid_nxt_s = 1'b0;
          cipo_nxt_s          = 1'b0;
          state_nxt_s         = IDLE;
        end else if (sclk_rise_s) begin
          rx_nxt_s      = rx_shift_s;
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
        end else if (sclk_fall_s && (bit_cnt_r != 3'd0)) begin
          // Count zero on a fall means the fresh byte's MSB is already out.
          tx_nxt_s   = {tx_r[SPI_BYTE_BITS-2:0], 1'b0};
          cipo_nxt_s = tx_r[SPI_BYTE_BITS-2];
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: begin
        address_valid_nxt_s = 1'b0;
        cipo_nxt_s          = 1'b0;
        state_nxt_s         = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_r         <= IDLE;
      bit_cnt_r       <= {SPI_CNT_BITS{1'b0}};
      rx_r            <= {SPI_BYTE_BITS{1'b0}};
      tx_r            <= {SPI_BYTE_BITS{1'b0}};
      address_r       <= {SPI_BYTE_BITS{1'b0}};
      data_r          <= {SPI_BYTE_BITS{1'b0}};
      address_valid_r <= 1'b0;
      data_valid_r    <= 1'b0;
      read_r          <= 1'b0;
      cipo_r          <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      bit_cnt_r       <= bit_cnt_nxt_s;
      rx_r            <= rx_nxt_s;
      tx_r            <= tx_nxt_s;
      address_r       <= address_nxt_s;
      data_r          <= data_nxt_s;
      address_valid_r <= address_valid_nxt_s;
      data_valid_r    <= data_valid_nxt_s;
      read_r          <= read_nxt_s;
      cipo_r          <= cipo_nxt_s;
    end
  end

  assign spi_cipo_out             = cipo_r;
  assign address_out              = address_r;
  assign address_out_valid        = address_valid_r;
  assign data_out                 = data_r;
  assign data_out_valid           = data_valid_r;
  assign peripheral_data_read_out = read_r;

endmodule
